soc_system_pio_irq: RTL and testbench



---
 rtl/soc_system_pio_irq.sv | 144 ++++++++++++++
 tb/tb_soc_system_pio_irq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_irq.sv
// Avalon-MM parallel I/O port: per-bit direction, atomic set/clear of outputs,
// synchronised inputs with edge capture, and a maskable level/edge interrupt.
module soc_system_pio_irq #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    IRQ_TYPE    = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_oe,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam logic [1:0] EDGE_SEL     = EDGE_TYPE[1:0];
    localparam logic       IRQ_IS_LEVEL = (IRQ_TYPE[1:0] == 2'd0);

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [31:0]           w_rd_word;

    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_cap;

    assign w_wr      = chipselect & ~write_n;
    assign w_wdata   = writedata[DATA_WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign out_port  = r_data_out;
    assign out_oe    = r_dir;

    // Input synchroniser chain plus the one-cycle-old copy used for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_in;
        end
    end

    // Edge selection and write-1-to-clear vector for the capture register
    always_comb begin
        w_rise = w_sync_in & ~r_prev;
        w_fall = ~w_sync_in & r_prev;
        case (EDGE_SEL)
            2'd0:    w_edge = w_rise;
            2'd1:    w_edge = w_fall;
            2'd2:    w_edge = w_rise | w_fall;
            default: w_edge = w_rise;
        endcase
        if (w_wr && (address == ADDR_EDGE)) begin
            w_clr = w_wdata;
        end else begin
            w_clr = '0;
        end
    end

    // Software-visible registers; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (address)
                    ADDR_DATA:   r_data_out <= w_wdata;
                    ADDR_DIR:    r_dir      <= w_wdata;
                    ADDR_MASK:   r_mask     <= w_wdata;
                    ADDR_OUTSET: r_data_out <= r_data_out | w_wdata;
                    ADDR_OUTCLR: r_data_out <= r_data_out & ~w_wdata;
                    default:     r_data_out <= r_data_out;
                endcase
            end else begin
                r_data_out <= r_data_out;
            end
        end
    end

    // Read multiplexer, zero-extended to the 32-bit bus
    always_comb begin
        case (address)
            ADDR_DATA: w_rd_mux = (r_data_out & r_dir) | (w_sync_in & ~r_dir);
            ADDR_DIR:  w_rd_mux = r_dir;
            ADDR_MASK: w_rd_mux = r_mask;
            ADDR_EDGE: w_rd_mux = r_cap;
            default:   w_rd_mux = '0;
        endcase
        w_rd_word                 = 32'd0;
        w_rd_word[DATA_WIDTH-1:0] = w_rd_mux;
    end

    // Registered read data, updated every cycle without a read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
        end else begin
            readdata <= w_rd_word;
        end
    end

    // Interrupt is combinational from registered state so it rises with the capture bit
    always_comb begin
        if (IRQ_IS_LEVEL) begin
            irq = |(w_sync_in & r_mask);
        end else begin
            irq = |(r_cap & r_mask);
        end
    end

endmodule

// File: tb/tb_soc_system_pio_irq.sv
// Randomised and directed bench for soc_system_pio_irq: two instances with
// different parameters checked against a delay-line reference model.
module tb_soc_system_pio_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_port;

    logic [31:0] rd0, rd1;
    logic [31:0] out0, oe0;
    logic [11:0] out1, oe1;
    logic        irq0, irq1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    soc_system_pio_irq #(
        .DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1),
        .RESET_VALUE(32'h0000_00A5)
    ) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .out_port(out0), .out_oe(oe0), .irq(irq0)
    );

    soc_system_pio_irq #(
        .DATA_WIDTH(12), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_TYPE(0),
        .RESET_VALUE(12'h5A3)
    ) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in_port[11:0]), .out_port(out1), .out_oe(oe1), .irq(irq1)
    );

    // Reference model: per-instance parameters and register images
    int          p_s    [2];
    int          p_edge [2];
    int          p_irq  [2];
    logic [31:0] p_wm   [2];
    logic [31:0] p_rst  [2];
    logic [31:0] m_dout [2];
    logic [31:0] m_dir  [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_cap  [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];
    logic [31:0] hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdmux(int i, logic [2:0] a, logic [31:0] s);
        case (a)
            3'd0:    return ((m_dout[i] & m_dir[i]) | (s & ~m_dir[i])) & p_wm[i];
            3'd1:    return m_dir[i];
            3'd2:    return m_mask[i];
            3'd3:    return m_cap[i];
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic [31:0] s_old, p_old, e, clr, wd, s_now;
        logic        wr;
        int          n;
        wr = chipselect & ~write_n;
        for (int i = 0; i < 2; i++) begin
            n     = hist.size();
            s_old = hist[n - p_s[i]] & p_wm[i];
            p_old = hist[n - p_s[i] - 1] & p_wm[i];
            wd    = writedata & p_wm[i];
            if (reset) begin
                m_dout[i] = p_rst[i];
                m_dir[i]  = 32'd0;
                m_mask[i] = 32'd0;
                m_cap[i]  = 32'd0;
                m_rd[i]   = 32'd0;
            end else begin
                m_rd[i] = rdmux(i, address, s_old);
                case (p_edge[i])
                    0:       e = s_old & ~p_old;
                    1:       e = ~s_old & p_old;
                    default: e = s_old ^ p_old;
                endcase
                clr = (wr && address == 3'd3) ? wd : 32'd0;
                m_cap[i] = (m_cap[i] & ~clr) | e;
                if (wr) begin
                    case (address)
                        3'd0: m_dout[i] = wd;
                        3'd1: m_dir[i]  = wd;
                        3'd2: m_mask[i] = wd;
                        3'd4: m_dout[i] = m_dout[i] | wd;
                        3'd5: m_dout[i] = m_dout[i] & ~wd;
                        default: ;
                    endcase
                end
            end
        end
        hist.push_back(in_port);
        if (reset) begin
            for (int k = 1; k <= 5; k++) hist[hist.size() - k] = 32'd0;
        end
        for (int i = 0; i < 2; i++) begin
            s_now = hist[hist.size() - p_s[i]] & p_wm[i];
            if (p_irq[i] == 0) m_irq[i] = |(s_now & m_mask[i]);
            else               m_irq[i] = |(m_cap[i] & m_mask[i]);
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] a, input logic cs,
                        input logic wn, input logic [31:0] wd, input logic [31:0] inp);
        @(negedge clk);
        reset      = rst;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        model_edge();
        #1;
        chk("rd0",  rd0,  m_rd[0]);
        chk("out0", out0, m_dout[0]);
        chk("oe0",  oe0,  m_dir[0]);
        chk("irq0", {31'd0, irq0}, {31'd0, m_irq[0]});
        chk("rd1",  rd1,  m_rd[1]);
        chk("out1", {20'd0, out1}, m_dout[1]);
        chk("oe1",  {20'd0, oe1},  m_dir[1]);
        chk("irq1", {31'd0, irq1}, {31'd0, m_irq[1]});
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [31:0] inp);
        step(1'b0, a, 1'b1, 1'b0, wd, inp);
    endtask

    task automatic idle(input logic [2:0] a, input logic [31:0] inp);
        step(1'b0, a, 1'b0, 1'b1, 32'd0, inp);
    endtask

    initial begin
        logic [31:0] cur_in;
        p_s[0] = 2;  p_edge[0] = 0; p_irq[0] = 1; p_wm[0] = 32'hFFFF_FFFF; p_rst[0] = 32'h0000_00A5;
        p_s[1] = 3;  p_edge[1] = 2; p_irq[1] = 0; p_wm[1] = 32'h0000_0FFF; p_rst[1] = 32'h0000_05A3;
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = 32'd0; m_dir[i] = 32'd0; m_mask[i] = 32'd0;
            m_cap[i] = 32'd0;  m_rd[i] = 32'd0;  m_irq[i] = 1'b0;
        end
        for (int k = 0; k < 6; k++) hist.push_back(32'd0);
        reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 32'd0;

        // Reset state
        repeat (3) step(1'b1, 3'd0, 1'b0, 1'b1, 32'd0, 32'd0);
        chk("rst_out", out0, 32'h0000_00A5);
        chk("rst_oe",  oe0,  32'd0);
        chk("rst_rd",  rd0,  32'd0);
        chk("rst_irq", {31'd0, irq0}, 32'd0);

        // Mixed direction readback
        wr_reg(3'd1, 32'h0000_FFFF, 32'hABCD_0000);
        wr_reg(3'd0, 32'h1234_5678, 32'hABCD_0000);
        repeat (3) idle(3'd0, 32'hABCD_0000);
        chk("data_mix", rd0, 32'hABCD_5678);

        // Atomic set then clear on consecutive cycles
        wr_reg(3'd4, 32'h0000_0F00, 32'hABCD_0000);
        wr_reg(3'd5, 32'h0000_0078, 32'hABCD_0000);
        chk("setclr", out0, 32'h1234_5F00);

        // Edge-capture interrupt latency and clear
        repeat (5) idle(3'd0, 32'd0);
        wr_reg(3'd2, 32'h0000_0001, 32'd0);
        wr_reg(3'd3, 32'hFFFF_FFFF, 32'd0);
        idle(3'd3, 32'h0000_0001);
        idle(3'd3, 32'd0);
        chk("irq_early", {31'd0, irq0}, 32'd0);
        idle(3'd3, 32'd0);
        chk("irq_set", {31'd0, irq0}, 32'd1);
        wr_reg(3'd3, 32'h0000_0001, 32'd0);
        chk("irq_clr", {31'd0, irq0}, 32'd0);

        // Clear colliding with a new edge on the same bit: set wins
        idle(3'd3, 32'h0000_0001);
        repeat (3) idle(3'd3, 32'd0);
        idle(3'd3, 32'h0000_0001);
        idle(3'd3, 32'h0000_0001);
        wr_reg(3'd3, 32'h0000_0001, 32'h0000_0001);
        idle(3'd3, 32'h0000_0001);
        chk("set_wins", rd0 & 32'h1, 32'h1);

        // Level interrupt on the second instance, then reset mid-hold
        wr_reg(3'd2, 32'h0000_0002, 32'h0000_0002);
        repeat (4) idle(3'd0, 32'h0000_0002);
        chk("lvl_irq", {31'd0, irq1}, 32'd1);
        step(1'b1, 3'd2, 1'b0, 1'b1, 32'd0, 32'h0000_0002);
        chk("lvl_rst_irq", {31'd0, irq1}, 32'd0);
        idle(3'd2, 32'h0000_0002);
        chk("lvl_rst_mask", rd1, 32'd0);

        // Randomised traffic
        cur_in = 32'h0000_0002;
        for (int t = 0; t < 400; t++) begin
            logic rst;
            cur_in = cur_in ^ ($urandom & $urandom & $urandom);
            rst = ($urandom_range(0, 63) == 0);
            step(rst, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0), $urandom, cur_in);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
